// File: rtl/multi_tick_irq.sv
// Multi-channel periodic tick generator with latched pending/overrun flags
// and a masked, registered interrupt request for an MCU ei_req input.
module multi_tick_irq #(
    parameter int N_CH           = 4,
    parameter int CNT_W          = 24,
    parameter int DEFAULT_PERIOD = 40000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   ch_en,
    input  logic [N_CH-1:0]   irq_mask,
    input  logic              wr_en,
    input  logic [3:0]        wr_ch,
    input  logic [CNT_W-1:0]  wr_period,
    input  logic [N_CH-1:0]   ack,
    input  logic [N_CH-1:0]   ovr_clr,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   pending,
    output logic [N_CH-1:0]   overrun,
    output logic              irq
);

    logic [CNT_W-1:0] counter_r [N_CH];
    logic [CNT_W-1:0] period_r  [N_CH];
    logic [N_CH-1:0]  tick_r;
    logic [N_CH-1:0]  pending_r;
    logic [N_CH-1:0]  overrun_r;
    logic             irq_r;

    logic [N_CH-1:0]  wsel_s;
    logic [N_CH-1:0]  wrap_s;
    logic [N_CH-1:0]  pend_nxt_s;
    logic [N_CH-1:0]  ovr_nxt_s;

    // Per-channel wrap detection and next-state of the sticky flags; a write
    // to a channel restarts it, so it cannot wrap on the same edge.
    always_comb begin
        wsel_s     = '0;
        wrap_s     = '0;
        pend_nxt_s = '0;
        ovr_nxt_s  = '0;
        for (int i = 0; i < N_CH; i++) begin
            wsel_s[i] = wr_en && (wr_ch == 4'(i));
            if (!wsel_s[i] && ch_en[i] && (period_r[i] != '0) &&
                (counter_r[i] == period_r[i] - CNT_W'(1))) begin
                wrap_s[i] = 1'b1;
            end else begin
                wrap_s[i] = 1'b0;
            end
            pend_nxt_s[i] = wrap_s[i] | (pending_r[i] & ~ack[i]);
            ovr_nxt_s[i]  = (wrap_s[i] & pending_r[i] & ~ack[i]) |
                            (overrun_r[i] & ~ovr_clr[i]);
        end
    end

    // Counters, periods, flags and the masked interrupt, all on one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                counter_r[i] <= '0;
                period_r[i]  <= CNT_W'(DEFAULT_PERIOD);
            end
            tick_r    <= '0;
            pending_r <= '0;
            overrun_r <= '0;
            irq_r     <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (wsel_s[i]) begin
                    period_r[i]  <= wr_period;
                    counter_r[i] <= '0;
                end else if (!ch_en[i] || (period_r[i] == '0) || wrap_s[i]) begin
                    counter_r[i] <= '0;
                end else begin
                    counter_r[i] <= counter_r[i] + CNT_W'(1);
                end
            end
            tick_r    <= wrap_s;
            pending_r <= pend_nxt_s;
            overrun_r <= ovr_nxt_s;
            irq_r     <= |(pend_nxt_s & irq_mask);
        end
    end

    assign tick    = tick_r;
    assign pending = pending_r;
    assign overrun = overrun_r;
    assign irq     = irq_r;

endmodule

// File: tb/tb_multi_tick_irq.sv
// Self-checking bench for multi_tick_irq: directed scenarios plus a random
// run, all compared against an elapsed-cycle behavioural model.
module tb_multi_tick_irq;

    localparam int N_CH  = 4;
    localparam int CNT_W = 24;
    localparam int DP    = 400;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       ch_en, irq_mask, ack, ovr_clr, wr_ch;
    logic             wr_en;
    logic [CNT_W-1:0] wr_period;
    logic [3:0]       tick, pending, overrun;
    logic             irq;

    int         m_per [N_CH];
    int         m_el  [N_CH];
    logic [3:0] m_tick, m_pend, m_ovr;
    logic       m_irq;

    int n_checks = 0;
    int n_fail   = 0;

    multi_tick_irq #(.N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_PERIOD(DP)) dut (
        .clk(clk), .reset(reset), .ch_en(ch_en), .irq_mask(irq_mask),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_period(wr_period), .ack(ack),
        .ovr_clr(ovr_clr), .tick(tick), .pending(pending),
        .overrun(overrun), .irq(irq)
    );

    always #5 clk = ~clk;

    // Model: a channel ticks whenever its count of consecutive enabled
    // cycles since the last restart is a multiple of its period.
    task automatic model_step();
        logic [3:0] wrap;
        wrap = 4'b0000;
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                m_per[i] = DP;
                m_el[i]  = 0;
            end
            m_tick = 4'b0000; m_pend = 4'b0000; m_ovr = 4'b0000; m_irq = 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (wr_en && wr_ch == 4'(i)) begin
                    m_per[i] = int'(wr_period);
                    m_el[i]  = 0;
                end else if (!ch_en[i] || m_per[i] == 0) begin
                    m_el[i] = 0;
                end else begin
                    m_el[i] = m_el[i] + 1;
                    wrap[i] = (m_el[i] % m_per[i] == 0);
                end
                if (wrap[i] && m_pend[i] && !ack[i]) m_ovr[i] = 1'b1;
                else if (ovr_clr[i])                  m_ovr[i] = 1'b0;
                if (wrap[i])     m_pend[i] = 1'b1;
                else if (ack[i]) m_pend[i] = 1'b0;
            end
            m_tick = wrap;
            m_irq  = |(m_pend & irq_mask);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [12:0] dut_v();
        return {tick, pending, overrun, irq};
    endfunction

    function automatic logic [12:0] exp_v();
        return {m_tick, m_pend, m_ovr, m_irq};
    endfunction

    task automatic idle_inputs();
        ch_en = 4'b0000; irq_mask = 4'b0000; ack = 4'b0000; ovr_clr = 4'b0000;
        wr_en = 1'b0; wr_ch = 4'd0; wr_period = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic write_period(input logic [3:0] ch, input int p);
        wr_en = 1'b1; wr_ch = ch; wr_period = CNT_W'(p);
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        int first;
        do_reset();
        n_checks++;
        if (dut_v() !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%b want=%b", dut_v(), 13'd0);
        end
        ch_en = 4'b0001; irq_mask = 4'b0001;
        first = -1;
        for (int c = 1; c <= DP; c++) begin
            step();
            if (tick[0] && first < 0) first = c;
            n_checks++;
            if (dut_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL reset_run cyc=%0d got=%b want=%b", c, dut_v(), exp_v());
            end
        end
        n_checks++;
        if (first != DP || pending[0] !== 1'b1 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL first_tick got_cyc=%0d pend=%b irq=%b want_cyc=%0d pend=1 irq=1",
                     first, pending[0], irq, DP);
        end
        ack = 4'b0001;
        step();
        ack = 4'b0000;
        n_checks++;
        if (pending[0] !== 1'b0 || irq !== 1'b0 || tick[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_clear got pend=%b irq=%b tick=%b want 0 0 0",
                     pending[0], irq, tick[0]);
        end
        first = -1;
        for (int c = 2; c <= DP + 1; c++) begin
            step();
            if (tick[0] && first < 0) first = c;
            n_checks++;
            if (dut_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL second_period cyc=%0d got=%b want=%b", c, dut_v(), exp_v());
            end
        end
        n_checks++;
        if (first != DP) begin
            n_fail++;
            $display("FAIL second_tick got_cyc=%0d want_cyc=%0d", first, DP);
        end
    endtask

    task automatic test_period_write();
        int nt;
        do_reset();
        ch_en = 4'b0010;
        write_period(4'd1, 5);
        nt = 0;
        for (int c = 1; c <= 16; c++) begin
            step();
            nt += int'(tick[1]);
            n_checks++;
            if (tick[1] !== (c % 5 == 0) || dut_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL period5 cyc=%0d got=%b want=%b tick1_want=%0d",
                         c, dut_v(), exp_v(), (c % 5 == 0));
            end
        end
        n_checks++;
        if (nt != 3) begin
            n_fail++;
            $display("FAIL period5_count got=%0d want=3", nt);
        end
        write_period(4'd1, 0);
        for (int c = 1; c <= 12; c++) begin
            step();
            n_checks++;
            if (tick[1] !== 1'b0 || dut_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL period0 cyc=%0d got=%b want=%b", c, dut_v(), exp_v());
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        ch_en = 4'b0100;
        write_period(4'd2, 3);
        step(); step(); step();
        n_checks++;
        if (pending[2] !== 1'b1 || overrun[2] !== 1'b0 || tick[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL first_wrap got pend=%b ovr=%b tick=%b want 1 0 1",
                     pending[2], overrun[2], tick[2]);
        end
        step(); step(); step();
        n_checks++;
        if (overrun[2] !== 1'b1 || dut_v() !== exp_v()) begin
            n_fail++;
            $display("FAIL overrun_set got=%b want=%b", dut_v(), exp_v());
        end
        ovr_clr = 4'b0100;
        step();
        ovr_clr = 4'b0000;
        n_checks++;
        if (overrun[2] !== 1'b0 || pending[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_clr got ovr=%b pend=%b want 0 1", overrun[2], pending[2]);
        end
        step();
        ack = 4'b0100;
        step();
        ack = 4'b0000;
        n_checks++;
        if (pending[2] !== 1'b1 || overrun[2] !== 1'b0 || tick[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_on_wrap got pend=%b ovr=%b tick=%b want 1 0 1",
                     pending[2], overrun[2], tick[2]);
        end
        ack = 4'b0100;
        step();
        ack = 4'b0000;
        n_checks++;
        if (pending[2] !== 1'b0 || dut_v() !== exp_v()) begin
            n_fail++;
            $display("FAIL ack_clear2 got=%b want=%b", dut_v(), exp_v());
        end
    endtask

    task automatic test_mask();
        do_reset();
        ch_en = 4'b1001;
        write_period(4'd0, 4);
        write_period(4'd3, 7);
        for (int c = 1; c <= 14; c++) begin
            step();
            n_checks++;
            if (irq !== 1'b0 || dut_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL masked cyc=%0d got=%b want=%b", c, dut_v(), exp_v());
            end
        end
        n_checks++;
        if (pending !== 4'b1001) begin
            n_fail++;
            $display("FAIL masked_pend got=%b want=1001", pending);
        end
        irq_mask = 4'b1000;
        step();
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL unmask_irq got=%b want=1", irq);
        end
    endtask

    task automatic test_midreset();
        int first;
        do_reset();
        ch_en = 4'b0001; irq_mask = 4'b0001;
        for (int c = 1; c <= DP / 2; c++) step();
        reset = 1'b1;
        wr_en = 1'b1; wr_ch = 4'd0; wr_period = CNT_W'(3);
        ack = 4'b1111; ovr_clr = 4'b1111;
        step();
        reset = 1'b0; wr_en = 1'b0; ack = 4'b0000; ovr_clr = 4'b0000;
        n_checks++;
        if (dut_v() !== 13'd0 || exp_v() !== 13'd0) begin
            n_fail++;
            $display("FAIL midreset got=%b want=%b", dut_v(), 13'd0);
        end
        wr_en = 1'b1; wr_ch = 4'd15; wr_period = CNT_W'(2);
        first = -1;
        for (int c = 1; c <= DP; c++) begin
            step();
            wr_en = 1'b0;
            if (tick[0] && first < 0) first = c;
            n_checks++;
            if (dut_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL post_reset cyc=%0d got=%b want=%b", c, dut_v(), exp_v());
            end
        end
        n_checks++;
        if (first != DP) begin
            n_fail++;
            $display("FAIL post_reset_tick got_cyc=%0d want_cyc=%0d", first, DP);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < N_CH; i++) write_period(4'(i), $urandom_range(1, 6));
        ch_en = 4'($urandom);
        irq_mask = 4'($urandom);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 15) == 0) ch_en = 4'($urandom);
            if ($urandom_range(0, 15) == 0) irq_mask = 4'($urandom);
            wr_en     = ($urandom_range(0, 7) == 0);
            wr_ch     = 4'($urandom_range(0, 15));
            wr_period = CNT_W'($urandom_range(0, 6));
            ack       = 4'($urandom & $urandom);
            ovr_clr   = 4'($urandom & $urandom & $urandom);
            step();
            n_checks++;
            if (dut_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b want=%b", c, dut_v(), exp_v());
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        m_tick = 4'b0000; m_pend = 4'b0000; m_ovr = 4'b0000; m_irq = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            m_per[i] = DP;
            m_el[i]  = 0;
        end
        test_reset();
        test_period_write();
        test_overrun();
        test_mask();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
